alarm_bank: RTL and testbench

- Multi-channel successor to the single alarm: N_ALRM independently programmable daily alarms with per-channel enable, snooze, and ring timeout.
- Compares each stored HH:MM against the running clock time. Drives one shared ring output and reports which channel is ringing.
- Sits beside the timekeeping counter and consumes its 11-bit {hour[4:0], min[5:0]} time bus.
- Its outputs feed the buzzer/LED driver and the display mux.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/time_add_min.sv | 35 +++
 rtl/alarm_bank.sv | 161 ++++++++++++++++
 tb/tb_alarm_bank.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared time-bus widths, limits, alarm FSM states and a helper that checks an
// {hour, min} word is a real wall-clock time.
package clock_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned TIME_W   = HOUR_W + MIN_W;
  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } alarm_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } hhmm_t;

  function automatic logic time_valid(input hhmm_t t);
    return (32'(t.hour) <= MAX_HOUR) && (32'(t.min) <= MAX_MIN);
  endfunction

endpackage

// File: rtl/time_add_min.sv
// Combinational HH:MM + ADD_MIN minutes, carrying into the hour and wrapping
// 23:xx past midnight back to hour 0.
module time_add_min
  import clock_pkg::*;
#(
  parameter int unsigned ADD_MIN = 5
) (
  input  logic [TIME_W-1:0] time_i,
  output logic [TIME_W-1:0] sum_c
);

  localparam int unsigned SUM_W = MIN_W + 1;

  hhmm_t             t_in;
  logic [SUM_W-1:0]  min_raw;
  logic              carry;
  logic [MIN_W-1:0]  min_out;
  logic [HOUR_W-1:0] hour_out;

  assign t_in    = hhmm_t'(time_i);
  assign min_raw = {1'b0, t_in.min} + SUM_W'(ADD_MIN);
  assign carry   = min_raw >= SUM_W'(MAX_MIN + 1);

  always_comb begin
    min_out  = min_raw[MIN_W-1:0];
    hour_out = t_in.hour;
    if (carry) begin
      min_out  = MIN_W'(min_raw - SUM_W'(MAX_MIN + 1));
      hour_out = (t_in.hour >= HOUR_W'(MAX_HOUR)) ? '0 : t_in.hour + HOUR_W'(1);
    end
  end

  assign sum_c = {hour_out, min_out};

endmodule

// File: rtl/alarm_bank.sv
// N_ALRM programmable daily alarms sharing one ring output: per-channel enable,
// snooze re-arm, lowest-index arbitration and a minute-based ring timeout.
module alarm_bank
  import clock_pkg::*;
#(
  parameter int unsigned N_ALRM      = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned SNOOZE_MIN  = 5,
  parameter int unsigned RING_TO_MIN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] time_in,
  input  logic [TIME_W-1:0] time_set_in,
  input  logic [IDX_W-1:0]  sel_in,
  input  logic              set_time,
  input  logic [N_ALRM-1:0] en_in,
  input  logic              snooze,
  input  logic              end_ring,
  output logic              ring,
  output logic [IDX_W-1:0]  ring_id,
  output logic [N_ALRM-1:0] snoozing
);

  logic [TIME_W-1:0] prev_time_q;
  logic [TIME_W-1:0] slot_q     [N_ALRM];
  logic [TIME_W-1:0] snz_time_q [N_ALRM];
  logic [N_ALRM-1:0] pending_q, pending_d;
  logic [N_ALRM-1:0] snoozing_q, snoozing_d;
  alarm_state_e      state_q;
  logic              ring_q;
  logic [IDX_W-1:0]  ring_id_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              tick;
  logic              wr_ok;
  logic              in_ring;
  logic              found;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_id;
  logic              ring_en;
  logic              do_snooze;
  logic              exit_ring;
  logic [N_ALRM-1:0] ready;
  logic [TIME_W-1:0] snz_sum;

  time_add_min #(
    .ADD_MIN(SNOOZE_MIN)
  ) u_snz_add (
    .time_i(time_in),
    .sum_c (snz_sum)
  );

  assign tick      = time_in != prev_time_q;
  assign wr_ok     = set_time && (32'(sel_in) < N_ALRM) && time_valid(hhmm_t'(time_set_in));
  assign in_ring   = state_q == RING;
  assign ready     = pending_q & en_in;

  // Lowest-index ready channel wins; also look up the ringing channel's enable.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    ring_en  = 1'b0;
    for (int i = 0; i < int'(N_ALRM); i++) begin
      if (ready[i] && !found) begin
        grant_id = IDX_W'(i);
        found    = 1'b1;
      end
      if (ring_id_q == IDX_W'(i)) begin
        ring_en = en_in[i];
      end
    end
  end

  assign grant_valid = !in_ring && found;
  assign do_snooze   = in_ring && snooze && !end_ring;
  assign exit_ring   = in_ring && (end_ring || snooze || !ring_en ||
                                   (cnt_q >= CNT_W'(RING_TO_MIN)));

  // Pending/snooze flags; disable has the last word, the ringing channel never re-queues.
  always_comb begin
    pending_d  = pending_q;
    snoozing_d = snoozing_q;
    for (int i = 0; i < int'(N_ALRM); i++) begin
      if (tick && snoozing_q[i] && (time_in == snz_time_q[i])) begin
        snoozing_d[i] = 1'b0;
        if (!(in_ring && (ring_id_q == IDX_W'(i)))) begin
          pending_d[i] = 1'b1;
        end
      end
      if (tick && (time_in == slot_q[i]) && !(in_ring && (ring_id_q == IDX_W'(i)))) begin
        pending_d[i] = 1'b1;
      end
      if (grant_valid && (grant_id == IDX_W'(i))) begin
        pending_d[i] = 1'b0;
      end
      if (do_snooze && (ring_id_q == IDX_W'(i))) begin
        snoozing_d[i] = 1'b1;
      end
      if (!en_in[i]) begin
        pending_d[i]  = 1'b0;
        snoozing_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_time_q <= time_in;
      pending_q   <= '0;
      snoozing_q  <= '0;
      state_q     <= IDLE;
      ring_q      <= 1'b0;
      ring_id_q   <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < int'(N_ALRM); i++) begin
        slot_q[i]     <= '0;
        snz_time_q[i] <= '0;
      end
    end else begin
      prev_time_q <= time_in;
      pending_q   <= pending_d;
      snoozing_q  <= snoozing_d;
      for (int i = 0; i < int'(N_ALRM); i++) begin
        if (wr_ok && (sel_in == IDX_W'(i))) begin
          slot_q[i] <= time_set_in;
        end
        if (do_snooze && (ring_id_q == IDX_W'(i))) begin
          snz_time_q[i] <= snz_sum;
        end
      end
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q   <= RING;
            ring_q    <= 1'b1;
            ring_id_q <= grant_id;
            cnt_q     <= '0;
          end
        end
        RING: begin
          if (exit_ring) begin
            state_q <= IDLE;
            ring_q  <= 1'b0;
          end else if (tick && (cnt_q < CNT_W'(RING_TO_MIN))) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ring     = ring_q;
  assign ring_id  = ring_id_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed, table-driven bench for alarm_bank; one minute of time_in is
// modelled as a handful of clock cycles.
module tb_alarm_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] time_in;
  logic [10:0] time_set_in;
  logic [1:0]  sel_in;
  logic        set_time;
  logic [3:0]  en_in;
  logic        snooze;
  logic        end_ring;
  logic        ring;
  logic [1:0]  ring_id;
  logic [3:0]  snoozing;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [10:0] t;
    logic [3:0]  en;
    int          cyc;
    logic        e_ring;
    logic [1:0]  e_id;
    logic [3:0]  e_snz;
    logic        wr;
    logic [1:0]  sel;
    logic [10:0] wt;
    logic        snz;
    logic        endr;
  } vec_t;

  vec_t vecs[$];

  alarm_bank dut (
    .clk        (clk),
    .rst        (rst),
    .time_in    (time_in),
    .time_set_in(time_set_in),
    .sel_in     (sel_in),
    .set_time   (set_time),
    .en_in      (en_in),
    .snooze     (snooze),
    .end_ring   (end_ring),
    .ring       (ring),
    .ring_id    (ring_id),
    .snoozing   (snoozing)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [10:0] hm(input int h, input int m);
    return {5'(h), 6'(m)};
  endfunction

  function automatic vec_t mk(input string nm, input logic [10:0] t, input logic [3:0] en,
                              input int cyc, input logic er, input logic [1:0] eid,
                              input logic [3:0] esnz, input logic wr = 1'b0,
                              input logic [1:0] sel = 2'd0, input logic [10:0] wt = 11'd0,
                              input logic snz = 1'b0, input logic endr = 1'b0);
    vec_t v;
    v.name = nm;   v.t = t;     v.en = en;   v.cyc = cyc;
    v.e_ring = er; v.e_id = eid; v.e_snz = esnz;
    v.wr = wr;     v.sel = sel; v.wt = wt;  v.snz = snz; v.endr = endr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive at the negedge, pulses last exactly one edge, sample at a later negedge.
  task automatic apply(input vec_t v);
    time_in     = v.t;
    en_in       = v.en;
    set_time    = v.wr;
    sel_in      = v.sel;
    time_set_in = v.wt;
    snooze      = v.snz;
    end_ring    = v.endr;
    @(posedge clk);
    #1;
    set_time = 1'b0;
    snooze   = 1'b0;
    end_ring = 1'b0;
    repeat (v.cyc - 1) @(posedge clk);
    @(negedge clk);
    chk({v.name, " ring"}, 32'(ring), 32'(v.e_ring));
    if (v.e_ring) chk({v.name, " ring_id"}, 32'(ring_id), 32'(v.e_id));
    chk({v.name, " snoozing"}, 32'(snoozing), 32'(v.e_snz));
  endtask

  initial begin
    rst = 1'b1;
    time_in = hm(8, 20);
    time_set_in = '0;
    sel_in = '0;
    set_time = 1'b0;
    en_in = '0;
    snooze = 1'b0;
    end_ring = 1'b0;

    // basic ring and dismiss
    vecs.push_back(mk("t1 program", hm(8, 20), 4'b0001, 2, 0, 0, 4'b0000, 1, 2'd0, hm(8, 30)));
    vecs.push_back(mk("t1 08:29", hm(8, 29), 4'b0001, 10, 0, 0, 4'b0000));
    vecs.push_back(mk("t1 match edge", hm(8, 30), 4'b0001, 1, 0, 0, 4'b0000));
    vecs.push_back(mk("t1 ring", hm(8, 30), 4'b0001, 1, 1, 2'd0, 4'b0000));
    vecs.push_back(mk("t1 end_ring", hm(8, 30), 4'b0001, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t1 no rering", hm(8, 30), 4'b0001, 7, 0, 0, 4'b0000));
    vecs.push_back(mk("t1 08:31", hm(8, 31), 4'b0001, 10, 0, 0, 4'b0000));
    // disabled channel and rejected writes
    vecs.push_back(mk("t2 08:29 off", hm(8, 29), 4'b0000, 3, 0, 0, 4'b0000));
    vecs.push_back(mk("t2 08:30 off", hm(8, 30), 4'b0000, 10, 0, 0, 4'b0000));
    vecs.push_back(mk("t2 wr 24:10", hm(8, 30), 4'b0000, 1, 0, 0, 4'b0000, 1, 2'd1, hm(24, 10)));
    vecs.push_back(mk("t2 wr 12:60", hm(8, 30), 4'b0000, 1, 0, 0, 4'b0000, 1, 2'd1, hm(12, 60)));
    vecs.push_back(mk("t2 slot1 still 00:00", hm(0, 0), 4'b0010, 2, 1, 2'd1, 4'b0000));
    vecs.push_back(mk("t2 dismiss", hm(0, 0), 4'b0010, 2, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    // snooze across midnight
    vecs.push_back(mk("t3 program", hm(23, 57), 4'b0100, 5, 0, 0, 4'b0000, 1, 2'd2, hm(23, 58)));
    vecs.push_back(mk("t3 ring 23:58", hm(23, 58), 4'b0100, 2, 1, 2'd2, 4'b0000));
    vecs.push_back(mk("t3 snooze", hm(23, 58), 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 0, 1));
    vecs.push_back(mk("t3 23:59", hm(23, 59), 4'b0100, 10, 0, 0, 4'b0100));
    vecs.push_back(mk("t3 00:00", hm(0, 0), 4'b0100, 10, 0, 0, 4'b0100));
    vecs.push_back(mk("t3 00:02", hm(0, 2), 4'b0100, 10, 0, 0, 4'b0100));
    vecs.push_back(mk("t3 00:03 edge", hm(0, 3), 4'b0100, 1, 0, 0, 4'b0000));
    vecs.push_back(mk("t3 re-ring", hm(0, 3), 4'b0100, 1, 1, 2'd2, 4'b0000));
    vecs.push_back(mk("t3 dismiss", hm(0, 3), 4'b0100, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    // two channels matching together
    vecs.push_back(mk("t4 wr slot1", hm(0, 3), 4'b0000, 1, 0, 0, 4'b0000, 1, 2'd1, hm(15, 45)));
    vecs.push_back(mk("t4 wr slot3", hm(0, 3), 4'b0000, 1, 0, 0, 4'b0000, 1, 2'd3, hm(15, 45)));
    vecs.push_back(mk("t4 15:44", hm(15, 44), 4'b1010, 5, 0, 0, 4'b0000));
    vecs.push_back(mk("t4 match edge", hm(15, 45), 4'b1010, 1, 0, 0, 4'b0000));
    vecs.push_back(mk("t4 first ch1", hm(15, 45), 4'b1010, 1, 1, 2'd1, 4'b0000));
    vecs.push_back(mk("t4 idle gap", hm(15, 45), 4'b1010, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t4 then ch3", hm(15, 45), 4'b1010, 1, 1, 2'd3, 4'b0000));
    vecs.push_back(mk("t4 dismiss ch3", hm(15, 45), 4'b1010, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    vecs.push_back(mk("t4 quiet", hm(15, 45), 4'b1010, 5, 0, 0, 4'b0000));
    // snooze+end_ring together, then disable mid-ring
    vecs.push_back(mk("t6 08:29", hm(8, 29), 4'b0001, 5, 0, 0, 4'b0000));
    vecs.push_back(mk("t6 ring", hm(8, 30), 4'b0001, 2, 1, 2'd0, 4'b0000));
    vecs.push_back(mk("t6 snz+end", hm(8, 30), 4'b0001, 1, 0, 0, 4'b0000, 0, 0, 0, 1, 1));
    vecs.push_back(mk("t6 no snooze at 08:35", hm(8, 35), 4'b0001, 3, 0, 0, 4'b0000));
    vecs.push_back(mk("t6b 08:29", hm(8, 29), 4'b0001, 5, 0, 0, 4'b0000));
    vecs.push_back(mk("t6b ring", hm(8, 30), 4'b0001, 2, 1, 2'd0, 4'b0000));
    vecs.push_back(mk("t6b disable", hm(8, 30), 4'b0000, 1, 0, 0, 4'b0000));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ring", 32'(ring), 32'd0);
    chk("reset ring_id", 32'(ring_id), 32'd0);
    chk("reset snoozing", 32'(snoozing), 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    // ring timeout after RING_TO_MIN minute changes
    apply(mk("t5 08:29", hm(8, 29), 4'b0001, 5, 0, 0, 4'b0000));
    apply(mk("t5 ring", hm(8, 30), 4'b0001, 2, 1, 2'd0, 4'b0000));
    for (int m = 31; m <= 39; m++) begin
      apply(mk($sformatf("t5 still ringing 08:%0d", m), hm(8, m), 4'b0001, 10, 1, 2'd0, 4'b0000));
    end
    apply(mk("t5 timeout 08:40", hm(8, 40), 4'b0001, 3, 0, 0, 4'b0000));

    // reset in the middle of a ring with a snooze armed elsewhere
    apply(mk("rs 08:29", hm(8, 29), 4'b0001, 5, 0, 0, 4'b0000));
    apply(mk("rs ring", hm(8, 30), 4'b0001, 2, 1, 2'd0, 4'b0000));
    apply(mk("rs snooze", hm(8, 30), 4'b0001, 1, 0, 0, 4'b0001, 0, 0, 0, 1));
    apply(mk("rs ring ch1", hm(15, 45), 4'b1011, 2, 1, 2'd1, 4'b0001));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mid-ring ring", 32'(ring), 32'd0);
    chk("rst mid-ring snoozing", 32'(snoozing), 32'd0);
    chk("rst mid-ring ring_id", 32'(ring_id), 32'd0);
    rst = 1'b0;
    apply(mk("rs pending cleared", hm(15, 45), 4'b1011, 10, 0, 0, 4'b0000));
    apply(mk("rs old snooze gone", hm(8, 35), 4'b1011, 10, 0, 0, 4'b0000));
    apply(mk("rs slots at 00:00", hm(0, 0), 4'b1011, 2, 1, 2'd0, 4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
